lcd_rect_fill_seq: RTL and testbench

LCD_RECT_FILL_SEQ -- requirements
Module: lcd_rect_fill_seq

---
 rtl/lcd_rect_fill_seq.sv | 275 +++++++++++++++++++++++++++
 tb/tb_lcd_rect_fill_seq.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_rect_fill_seq.sv
// Rectangle-fill sequencer for an lcd_module register bus: waits for panel init,
// then paints one pixel at a time (position, go, poll) in row-major order.
module lcd_rect_fill_seq #(
    parameter int ADDRESS_WIDTH = 12,
    parameter int LCD_W_P       = 128,
    parameter int LCD_H_P       = 128,
    parameter int TIMEOUT_CYC   = 1024
) (
    input  logic                     up_clk,
    input  logic                     up_rstn,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [15:0]              cmd_x,
    input  logic [15:0]              cmd_y,
    input  logic [15:0]              cmd_w,
    input  logic [15:0]              cmd_h,
    input  logic [15:0]              cmd_color,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic                     up_wreq,
    output logic [ADDRESS_WIDTH-1:0] up_waddr,
    output logic [31:0]              up_wdata,
    input  logic                     up_wack,
    output logic                     up_rreq,
    output logic [ADDRESS_WIDTH-1:0] up_raddr,
    input  logic [31:0]              up_rdata,
    input  logic                     up_rack
);

    typedef enum logic [2:0] {
        S_INIT_POLL,
        S_IDLE,
        S_WR_COL,
        S_WR_POS,
        S_WR_GO,
        S_POLL_DONE,
        S_FINISH
    } state_t;

    localparam int TO_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    localparam logic [ADDRESS_WIDTH-1:0] A_CTRL = ADDRESS_WIDTH'(0);
    localparam logic [ADDRESS_WIDTH-1:0] A_STAT = ADDRESS_WIDTH'(1);
    localparam logic [ADDRESS_WIDTH-1:0] A_POS  = ADDRESS_WIDTH'(2);
    localparam logic [ADDRESS_WIDTH-1:0] A_COL  = ADDRESS_WIDTH'(4);

    state_t                   state_q;
    logic                     cmd_ready_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     err_q;
    logic                     abort_q;
    logic                     up_wreq_q;
    logic                     up_rreq_q;
    logic [ADDRESS_WIDTH-1:0] up_waddr_q;
    logic [ADDRESS_WIDTH-1:0] up_raddr_q;
    logic [31:0]              up_wdata_q;
    logic [TO_W-1:0]          to_cnt_q;
    logic [16:0]              x0_q;
    logic [16:0]              cx_q;
    logic [16:0]              cy_q;
    logic [16:0]              x_end_q;
    logic [16:0]              y_end_q;
    logic [15:0]              color_q;

    logic        waiting;
    logic        to_hit;
    logic        abort_now;
    logic        in_range;
    logic        last_px;
    logic        row_end;
    logic        empty_cmd;
    logic [16:0] x_end_d;
    logic [16:0] y_end_d;
    logic [16:0] cx_d;
    logic [16:0] cy_d;
    logic        unused_rdata;

    // A request is "waiting" for every cycle it is high without its ack.
    assign waiting   = (up_wreq_q & ~up_wack) | (up_rreq_q & ~up_rack);
    assign to_hit    = waiting & (to_cnt_q == TO_LAST);
    assign abort_now = abort_q | (busy_q & abort);
    assign in_range  = (cx_q < 17'(LCD_W_P)) && (cy_q < 17'(LCD_H_P));
    assign row_end   = (cx_q == x_end_q);
    assign last_px   = row_end && (cy_q == y_end_q);
    assign empty_cmd = (cmd_w == 16'd0) || (cmd_h == 16'd0);
    assign x_end_d   = {1'b0, cmd_x} + {1'b0, cmd_w} - 17'd1;
    assign y_end_d   = {1'b0, cmd_y} + {1'b0, cmd_h} - 17'd1;
    assign cx_d      = row_end ? x0_q : cx_q + 17'd1;
    assign cy_d      = row_end ? cy_q + 17'd1 : cy_q;
    assign unused_rdata = ^{up_rdata[31:5], up_rdata[2:0]};

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            state_q     <= S_INIT_POLL;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            abort_q     <= 1'b0;
            up_wreq_q   <= 1'b0;
            up_rreq_q   <= 1'b0;
            up_waddr_q  <= '0;
            up_raddr_q  <= '0;
            up_wdata_q  <= '0;
            to_cnt_q    <= '0;
            x0_q        <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            x_end_q     <= '0;
            y_end_q     <= '0;
            color_q     <= '0;
        end else begin
            done_q <= 1'b0;
            if (waiting) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end else begin
                to_cnt_q <= '0;
            end
            if (busy_q && abort) begin
                abort_q <= 1'b1;
            end

            // Each bus op: raise the request from a low cycle, hold it until ack or timeout.
            unique case (state_q)
                S_INIT_POLL: begin
                    if (!up_rreq_q) begin
                        up_rreq_q  <= 1'b1;
                        up_raddr_q <= A_STAT;
                    end else if (up_rack) begin
                        up_rreq_q <= 1'b0;
                        if (up_rdata[3]) begin
                            state_q     <= S_IDLE;
                            cmd_ready_q <= 1'b1;
                        end
                    end else if (to_hit) begin
                        up_rreq_q   <= 1'b0;
                        err_q       <= 1'b1;
                        state_q     <= S_IDLE;
                        cmd_ready_q <= 1'b1;
                    end
                end

                S_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        abort_q     <= 1'b0;
                        x0_q        <= {1'b0, cmd_x};
                        cx_q        <= {1'b0, cmd_x};
                        cy_q        <= {1'b0, cmd_y};
                        x_end_q     <= x_end_d;
                        y_end_q     <= y_end_d;
                        color_q     <= cmd_color;
                        if (empty_cmd) begin
                            state_q <= S_FINISH;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_WR_COL;
                        end
                    end
                end

                S_WR_COL: begin
                    if (!up_wreq_q) begin
                        up_wreq_q  <= 1'b1;
                        up_waddr_q <= A_COL;
                        up_wdata_q <= {16'd0, color_q};
                    end else if (up_wack) begin
                        up_wreq_q <= 1'b0;
                        if (abort_now) begin
                            state_q <= S_FINISH;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_WR_POS;
                        end
                    end else if (to_hit) begin
                        up_wreq_q <= 1'b0;
                        err_q     <= 1'b1;
                        state_q   <= S_FINISH;
                        done_q    <= 1'b1;
                    end
                end

                S_WR_POS: begin
                    if (!up_wreq_q) begin
                        if (in_range) begin
                            up_wreq_q  <= 1'b1;
                            up_waddr_q <= A_POS;
                            up_wdata_q <= {cx_q[15:0], cy_q[15:0]};
                        end else if (abort_now || last_px) begin
                            state_q <= S_FINISH;
                            done_q  <= 1'b1;
                        end else begin
                            cx_q <= cx_d;
                            cy_q <= cy_d;
                        end
                    end else if (up_wack) begin
                        up_wreq_q <= 1'b0;
                        state_q   <= S_WR_GO;
                    end else if (to_hit) begin
                        up_wreq_q <= 1'b0;
                        err_q     <= 1'b1;
                        state_q   <= S_FINISH;
                        done_q    <= 1'b1;
                    end
                end

                S_WR_GO: begin
                    if (!up_wreq_q) begin
                        up_wreq_q  <= 1'b1;
                        up_waddr_q <= A_CTRL;
                        up_wdata_q <= 32'd1;
                    end else if (up_wack) begin
                        up_wreq_q <= 1'b0;
                        state_q   <= S_POLL_DONE;
                    end else if (to_hit) begin
                        up_wreq_q <= 1'b0;
                        err_q     <= 1'b1;
                        state_q   <= S_FINISH;
                        done_q    <= 1'b1;
                    end
                end

                S_POLL_DONE: begin
                    if (!up_rreq_q) begin
                        up_rreq_q  <= 1'b1;
                        up_raddr_q <= A_STAT;
                    end else if (up_rack) begin
                        up_rreq_q <= 1'b0;
                        if (up_rdata[4]) begin
                            if (abort_now || last_px) begin
                                state_q <= S_FINISH;
                                done_q  <= 1'b1;
                            end else begin
                                cx_q    <= cx_d;
                                cy_q    <= cy_d;
                                state_q <= S_WR_POS;
                            end
                        end
                    end else if (to_hit) begin
                        up_rreq_q <= 1'b0;
                        err_q     <= 1'b1;
                        state_q   <= S_FINISH;
                        done_q    <= 1'b1;
                    end
                end

                S_FINISH: begin
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end

                default: begin
                    state_q <= S_INIT_POLL;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign up_wreq   = up_wreq_q;
    assign up_waddr  = up_waddr_q;
    assign up_wdata  = up_wdata_q;
    assign up_rreq   = up_rreq_q;
    assign up_raddr  = up_raddr_q;

endmodule

// File: tb/tb_lcd_rect_fill_seq.sv
// Bench for lcd_rect_fill_seq: an lcd_module responder plus a transaction-level
// model of the expected register traffic, checked as each handshake completes.
module tb_lcd_rect_fill_seq;

    localparam int AW    = 12;
    localparam int TO    = 16;
    localparam int LCD_W = 128;
    localparam int LCD_H = 128;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [15:0]   cmd_x = '0, cmd_y = '0, cmd_w = '0, cmd_h = '0, cmd_color = '0;
    logic          abort = 1'b0;
    logic          busy, done, err;
    logic          up_wreq;
    logic [AW-1:0] up_waddr;
    logic [31:0]   up_wdata;
    logic          up_wack = 1'b0;
    logic          up_rreq;
    logic [AW-1:0] up_raddr;
    logic [31:0]   up_rdata = '0;
    logic          up_rack = 1'b0;

    always #5 clk = ~clk;

    lcd_rect_fill_seq #(
        .ADDRESS_WIDTH(AW), .LCD_W_P(LCD_W), .LCD_H_P(LCD_H), .TIMEOUT_CYC(TO)
    ) dut (
        .up_clk(clk), .up_rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
        .abort(abort), .busy(busy), .done(done), .err(err),
        .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wack(up_wack),
        .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata), .up_rack(up_rack)
    );

    typedef struct {
        bit          wr;
        int unsigned addr;
        logic [31:0] data;
    } txn_t;

    txn_t exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    // responder configuration and activity counters
    int wdelay = 1, rdelay = 0, init_zero = 0, poll_busy = 0, poll_left = 0;
    bit wack_never = 0;
    int rd_cnt = 0, wr_cnt = 0, w2_cnt = 0, done_cnt = 0, wreq_cyc = 0, rreq_cyc = 0;
    bit w_hold = 0, w_acked = 0, r_hold = 0, r_acked = 0;
    int wcnt = 0, rcnt = 0;
    logic [AW-1:0] h_waddr = '0, h_raddr = '0;
    logic [31:0]   h_wdata = '0;

    int lit_addr [13] = '{4, 2, 0, 1, 2, 0, 1, 2, 0, 1, 2, 0, 1};
    logic [31:0] lit_data [13] = '{32'h0000F800, 32'h000A0014, 32'h1, 32'h0,
                                   32'h000B0014, 32'h1, 32'h0,
                                   32'h000A0015, 32'h1, 32'h0,
                                   32'h000B0015, 32'h1, 32'h0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push(input bit wr, input int unsigned a, input logic [31:0] d);
        txn_t t;
        t.wr = wr; t.addr = a; t.data = d;
        exp_q.push_back(t);
    endtask

    task automatic model_init(input int zeros);
        for (int i = 0; i <= zeros; i++) push(1'b0, 1, 32'd0);
    endtask

    // Expected traffic for a fill: colour once, then pos/go/polls per on-panel pixel.
    task automatic model_rect(input int x, input int y, input int w, input int h,
                              input logic [15:0] col, input int polls, input int stop_after);
        int painted;
        logic [31:0] px32, py32;
        painted = 0;
        if (w == 0 || h == 0) return;
        push(1'b1, 4, {16'd0, col});
        for (int py = y; py < y + h; py++) begin
            for (int px = x; px < x + w; px++) begin
                if (!(stop_after > 0 && painted >= stop_after) && px < LCD_W && py < LCD_H) begin
                    px32 = px; py32 = py;
                    push(1'b1, 2, {px32[15:0], py32[15:0]});
                    push(1'b1, 0, 32'd1);
                    for (int k = 0; k < polls; k++) push(1'b0, 1, 32'd0);
                    painted++;
                end
            end
        end
    endtask

    task automatic expect_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data);
        txn_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_txn: got %s addr %0h data %0h, required none",
                     wr ? "write" : "read", addr, data);
        end else begin
            e = exp_q.pop_front();
            check("txn_kind", {31'd0, wr}, {31'd0, e.wr});
            check("txn_addr", addr, e.addr);
            if (wr) check("txn_data", data, e.data);
        end
    endtask

    // Responder and per-cycle protocol checks, all on the falling edge.
    always @(negedge clk) begin
        if (!rstn) begin
            up_wack = 0; up_rack = 0;
            w_hold = 0; w_acked = 0; r_hold = 0; r_acked = 0; wcnt = 0; rcnt = 0;
        end else begin
            if (w_acked) check("wreq_drop_after_ack", {31'd0, up_wreq}, 0);
            if (w_hold) begin
                if (wcnt >= TO) begin
                    check("wreq_drop_on_timeout", {31'd0, up_wreq}, 0);
                end else begin
                    check("wreq_hold", {31'd0, up_wreq}, 1);
                    check("waddr_hold", {20'd0, up_waddr}, {20'd0, h_waddr});
                    check("wdata_hold", up_wdata, h_wdata);
                end
            end
            if (r_acked) check("rreq_gap", {31'd0, up_rreq}, 0);
            if (r_hold && rcnt < TO) begin
                check("rreq_hold", {31'd0, up_rreq}, 1);
                check("raddr_hold", {20'd0, up_raddr}, {20'd0, h_raddr});
            end
            check("ready_busy_excl", {31'd0, cmd_ready & busy}, 0);
            check("done_within_busy", {31'd0, done & ~busy}, 0);
            if (done) done_cnt++;
            if (up_wreq) wreq_cyc++;
            if (up_rreq) rreq_cyc++;

            w_acked = 0; w_hold = 0; up_wack = 0;
            if (up_wreq) begin
                if (!wack_never && wcnt >= wdelay) begin
                    up_wack = 1; w_acked = 1; wcnt = 0; wr_cnt++;
                    if (up_waddr == 2) w2_cnt++;
                    expect_txn(1'b1, {20'd0, up_waddr}, up_wdata);
                end else begin
                    wcnt++; w_hold = 1; h_waddr = up_waddr; h_wdata = up_wdata;
                end
            end else begin
                wcnt = 0;
            end

            r_acked = 0; r_hold = 0; up_rack = 0;
            if (up_rreq) begin
                if (rcnt >= rdelay) begin
                    up_rack = 1; r_acked = 1; rcnt = 0; rd_cnt++;
                    up_rdata = '0;
                    if (init_zero > 0) init_zero--; else up_rdata[3] = 1'b1;
                    if (poll_left > 0) poll_left--;
                    else begin up_rdata[4] = 1'b1; poll_left = poll_busy; end
                    expect_txn(1'b0, {20'd0, up_raddr}, 32'd0);
                end else begin
                    rcnt++; r_hold = 1; h_raddr = up_raddr;
                end
            end else begin
                rcnt = 0;
            end
        end
    end

    task automatic send_cmd(input int x, input int y, input int w, input int h, input logic [15:0] col);
        int i;
        cmd_x = x[15:0]; cmd_y = y[15:0]; cmd_w = w[15:0]; cmd_h = h[15:0]; cmd_color = col;
        cmd_valid = 1'b1;
        i = 0;
        while (!cmd_ready && i < 300) begin @(negedge clk); i++; end
        check("cmd_ready_seen", {31'd0, cmd_ready}, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done_idle(input string name);
        int i;
        i = 0;
        while (!done && i < 400) begin @(negedge clk); i++; end
        check({name, "_done"}, {31'd0, done}, 1);
        @(negedge clk);
        check({name, "_busy_fell"}, {31'd0, busy}, 0);
        check({name, "_ready"}, {31'd0, cmd_ready}, 1);
    endtask

    task automatic wait_ready(input string name);
        int i;
        i = 0;
        while (!cmd_ready && i < 400) begin @(negedge clk); i++; end
        check({name, "_ready"}, {31'd0, cmd_ready}, 1);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_wreq"}, {31'd0, up_wreq}, 0);
        check({name, "_rreq"}, {31'd0, up_rreq}, 0);
        check({name, "_waddr"}, {20'd0, up_waddr}, 0);
        check({name, "_raddr"}, {20'd0, up_raddr}, 0);
        check({name, "_wdata"}, up_wdata, 0);
        check({name, "_ready"}, {31'd0, cmd_ready}, 0);
        check({name, "_busy"}, {31'd0, busy}, 0);
        check({name, "_done"}, {31'd0, done}, 0);
        check({name, "_err"}, {31'd0, err}, 0);
    endtask

    initial begin
        #500000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0, dn0, w20, wc0, rc0, i;

        // Reset, then init handshake: 5 not-ready status reads, then ready.
        init_zero = 5;
        model_init(5);
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rd0 = rd_cnt;
        rstn = 1'b1;
        wait_ready("init");
        check("init_read_count", rd_cnt - rd0, 6);
        check("init_queue_empty", exp_q.size(), 0);

        // 2x2 fill at (10,20); the model is pinned to the hand-written sequence first.
        model_rect(10, 20, 2, 2, 16'hF800, 1, 0);
        check("model_len_2x2", exp_q.size(), 13);
        for (int k = 0; k < 13 && k < exp_q.size(); k++) begin
            check("model_addr_2x2", exp_q[k].addr, lit_addr[k]);
            if (lit_addr[k] != 1) check("model_data_2x2", exp_q[k].data, lit_data[k]);
        end
        dn0 = done_cnt;
        send_cmd(10, 20, 2, 2, 16'hF800);
        wait_done_idle("fill2x2");
        check("fill2x2_one_done", done_cnt - dn0, 1);
        check("fill2x2_queue_empty", exp_q.size(), 0);

        // Right-edge clipping: only two of four pixels are on the panel.
        model_rect(126, 127, 4, 1, 16'h07E0, 1, 0);
        check("model_len_clip", exp_q.size(), 7);
        w20 = w2_cnt;
        send_cmd(126, 127, 4, 1, 16'h07E0);
        wait_done_idle("clip");
        check("clip_pos_writes", w2_cnt - w20, 2);
        check("clip_queue_empty", exp_q.size(), 0);

        // Zero width: done one cycle after acceptance, no bus traffic at all.
        wc0 = wreq_cyc; rc0 = rreq_cyc; dn0 = done_cnt;
        send_cmd(5, 5, 0, 3, 16'h1111);
        check("w0_done_next_cycle", {31'd0, done}, 1);
        check("w0_ready_low", {31'd0, cmd_ready}, 0);
        @(negedge clk);
        check("w0_ready_back", {31'd0, cmd_ready}, 1);
        check("w0_done_single", {31'd0, done}, 0);
        check("w0_no_wreq", wreq_cyc - wc0, 0);
        check("w0_no_rreq", rreq_cyc - rc0, 0);
        check("w0_one_done", done_cnt - dn0, 1);

        // Single pixel, immediate write acks, pixel_done only on the third poll.
        wdelay = 0; poll_busy = 2; poll_left = 2;
        model_rect(5, 6, 1, 1, 16'h001F, 3, 0);
        send_cmd(5, 6, 1, 1, 16'h001F);
        wait_done_idle("poll3");
        check("poll3_queue_empty", exp_q.size(), 0);
        poll_busy = 0; poll_left = 0; wdelay = 1;

        // Abort during the first pixel's go-write of a 4x4 command.
        model_rect(0, 0, 4, 4, 16'hFFFF, 1, 1);
        send_cmd(0, 0, 4, 4, 16'hFFFF);
        i = 0;
        while (!(up_wreq && up_waddr == 0) && i < 100) begin @(negedge clk); i++; end
        check("abort_go_seen", {31'd0, up_wreq}, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done_idle("abort");
        check("abort_queue_empty", exp_q.size(), 0);

        // Write ack never arrives: err, request dropped, done, back to idle.
        wack_never = 1;
        dn0 = done_cnt;
        send_cmd(1, 1, 1, 1, 16'h0F0F);
        i = 0;
        while (!done && i < 200) begin @(negedge clk); i++; end
        check("timeout_done", {31'd0, done}, 1);
        check("timeout_err", {31'd0, err}, 1);
        check("timeout_wreq_low", {31'd0, up_wreq}, 0);
        @(negedge clk);
        check("timeout_idle_ready", {31'd0, cmd_ready}, 1);
        check("timeout_one_done", done_cnt - dn0, 1);
        wack_never = 0;

        // Reset in the middle of status polling, then init resumes.
        poll_busy = 1000; poll_left = 1000;
        model_rect(3, 3, 1, 1, 16'hAAAA, 1001, 0);
        send_cmd(3, 3, 1, 1, 16'hAAAA);
        i = 0;
        while (!(busy && up_rreq) && i < 100) begin @(negedge clk); i++; end
        check("midpoll_reached", {31'd0, up_rreq}, 1);
        #2 rstn = 1'b0;
        #1 check_all_zero("async_reset");
        repeat (3) @(negedge clk);
        exp_q.delete();
        poll_busy = 0; poll_left = 0; init_zero = 2;
        model_init(2);
        rd0 = rd_cnt;
        rstn = 1'b1;
        wait_ready("reinit");
        check("reinit_read_count", rd_cnt - rd0, 3);
        check("reinit_queue_empty", exp_q.size(), 0);

        // One more pixel on the bottom edge after re-init.
        model_rect(0, 127, 1, 1, 16'h1234, 1, 0);
        send_cmd(0, 127, 1, 1, 16'h1234);
        wait_done_idle("post_reset");
        check("post_reset_queue_empty", exp_q.size(), 0);
        check("post_reset_err_clear", {31'd0, err}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
